// File: rtl/s1_link_pkg.sv
// Shared sizes and FSM state encoding for the S1 end of the S1/S2 serial link.
package s1_link_pkg;

    localparam int ADDR_W     = 3;
    localparam int DATA_W     = 18;
    localparam int NUM_WORDS  = 8;
    localparam int FRAME_BITS = ADDR_W + DATA_W;
    localparam int CNT_W      = 5;

    typedef enum logic [3:0] {
        IDLE,
        FETCH_A,
        FETCH_Q,
        SEND,
        GAP,
        RX_WAIT,
        RX_SHIFT,
        RX_WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/s1_link_shifter.sv
// Frame shift register with parallel load and bit counter, shared by the
// transmit path (shift out MSB) and the receive path (shift in at LSB).
module link_frame_shifter
    import s1_link_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic [FRAME_BITS-1:0] i_load_val,
    input  logic                  i_shift,
    input  logic                  i_shift_in,
    output logic [FRAME_BITS-1:0] o_data,
    output logic                  o_msb,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_frame_full
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

    logic [FRAME_BITS-1:0] r_data;
    logic [CNT_W-1:0]      r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_data  <= i_load_val;
            r_count <= '0;
        end else if (i_shift) begin
            r_data  <= {r_data[FRAME_BITS-2:0], i_shift_in};
            r_count <= r_count + 1'b1;
        end
    end

    assign o_data       = r_data;
    assign o_msb        = r_data[FRAME_BITS-1];
    assign o_count      = r_count;
    assign o_frame_full = (r_count == FULL_CNT);

endmodule

// File: rtl/s1_link.sv
// S1 initiator: moves the 8-word RB1 bank to S2 (updown=1) or fills it from
// S2 (updown=0) over the sen/sd pair; S1 only drives the pins while transmitting.
module s1_link
    import s1_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              updown,
    output logic              S1_done,
    output logic              RB1_RW,
    output logic [ADDR_W-1:0] RB1_A,
    output logic [DATA_W-1:0] RB1_D,
    input  logic [DATA_W-1:0] RB1_Q,
    inout  wire               sen,
    inout  wire               sd
);

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_W-1:0]     r_word;
    logic                  r_sen_prev;
    logic                  w_start;
    logic                  w_clr;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_shift_in;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_msb;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_tx_drv;
    logic                  w_sen_o;
    logic                  w_sd_o;

    link_frame_shifter u_shifter (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_load       (w_load),
        .i_load_val   ({r_word, RB1_Q}),
        .i_shift      (w_shift),
        .i_shift_in   (w_shift_in),
        .o_data       (w_frame),
        .o_msb        (w_msb),
        .o_count      (w_count),
        .o_frame_full (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // A frame may only start after sen has been seen high, so a long frame tail is ignored.
    assign w_start = (r_state == RX_WAIT) && !sen && r_sen_prev;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = updown ? FETCH_A : RX_WAIT;
            FETCH_A:  w_next = FETCH_Q;
            FETCH_Q:  w_next = SEND;
            SEND:     if (w_count == LAST_BIT) w_next = GAP;
            GAP:      w_next = (r_word == LAST_WORD) ? DONE : FETCH_A;
            RX_WAIT:  if (w_start) w_next = RX_SHIFT;
            RX_SHIFT: begin
                if (sen)                        w_next = RX_WAIT;
                else if (w_count == LAST_BIT)   w_next = RX_WRITE;
            end
            RX_WRITE: w_next = (r_word == LAST_WORD) ? DONE : RX_WAIT;
            DONE:     w_next = DONE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_tx_drv = 1'b0;
        w_sen_o  = 1'b1;
        w_sd_o   = 1'b0;
        RB1_RW   = 1'b1;
        RB1_A    = r_word;
        RB1_D    = '0;
        S1_done  = 1'b0;
        case (r_state)
            FETCH_A, FETCH_Q, GAP: w_tx_drv = 1'b1;
            SEND: begin
                w_tx_drv = 1'b1;
                w_sen_o  = 1'b0;
                w_sd_o   = w_msb;
            end
            RX_WRITE: begin
                RB1_RW = ~w_full;
                RB1_A  = w_frame[FRAME_BITS-1 -: ADDR_W];
                RB1_D  = w_frame[DATA_W-1:0];
            end
            DONE:    S1_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_load     = (r_state == FETCH_Q);
        w_clr      = (r_state == GAP) || (r_state == RX_WRITE) ||
                     ((r_state == RX_SHIFT) && sen);
        w_shift    = (r_state == SEND) || w_start ||
                     ((r_state == RX_SHIFT) && !sen);
        w_shift_in = (r_state == SEND) ? 1'b0 : sd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= '0;
            r_sen_prev <= 1'b0;
        end else begin
            r_sen_prev <= sen;
            if (r_state == GAP || r_state == RX_WRITE)
                r_word <= r_word + 1'b1;
        end
    end

    assign sen = w_tx_drv ? w_sen_o : 1'bz;
    assign sd  = w_tx_drv ? w_sd_o  : 1'bz;

endmodule
